vga_timing_generator: RTL



---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_axis_timer.sv | 71 +++++++
 rtl/vga_timing_generator.sv | 105 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 defaults for the VGA raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_phase_t;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = H_ACTIVE_DEF,
  parameter int FRONT_LEN  = H_FRONT_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF,
  parameter int BACK_LEN   = H_BACK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output vga_phase_t       phase,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  if (ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1) begin : g_len_error
    $error("vga_axis_timer: every phase length must be at least 1");
  end

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_phase_cnt;
  vga_phase_t       r_phase;
  vga_phase_t       w_phase_next;
  logic [CNT_W-1:0] w_phase_last;
  logic             w_phase_done;

  always_comb begin
    w_phase_last = CNT_W'(ACTIVE_LEN - 1);
    w_phase_next = r_phase;
    case (r_phase)
      ACTIVE: w_phase_last = CNT_W'(ACTIVE_LEN - 1);
      FRONT:  w_phase_last = CNT_W'(FRONT_LEN - 1);
      SYNC:   w_phase_last = CNT_W'(SYNC_LEN - 1);
      BACK:   w_phase_last = CNT_W'(BACK_LEN - 1);
      default: w_phase_last = CNT_W'(ACTIVE_LEN - 1);
    endcase
    w_phase_done = (r_phase_cnt == w_phase_last);
    if (advance && w_phase_done) begin
      case (r_phase)
        ACTIVE:  w_phase_next = FRONT;
        FRONT:   w_phase_next = SYNC;
        SYNC:    w_phase_next = BACK;
        BACK:    w_phase_next = ACTIVE;
        default: w_phase_next = ACTIVE;
      endcase
    end
  end

  assign wrap = advance && (r_count == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_phase_cnt <= '0;
      r_phase     <= ACTIVE;
    end else if (advance) begin
      r_count     <= wrap ? '0 : r_count + 1'b1;
      r_phase_cnt <= w_phase_done ? '0 : r_phase_cnt + 1'b1;
      r_phase     <= w_phase_next;
    end
  end

  assign count = r_count;
  assign phase = r_phase;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: horizontal and vertical axis timers with a registered,
// mutually aligned output decode (syncs, enable, coordinates, pulses).
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             display_enable,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_end,
  output logic             frame_start
);

  localparam int   H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic SYNC_ON = SYNC_ACTIVE_HIGH;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_error
    $error("vga_timing_generator: H_TOTAL=%0d V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
  end

  logic [CNT_W-1:0] w_h_count;
  logic [CNT_W-1:0] w_v_count;
  vga_phase_t       w_h_phase;
  vga_phase_t       w_v_phase;
  logic             w_h_wrap;
  logic             w_v_wrap;

  vga_axis_timer #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h_timer (
    .clock  (clock),
    .reset  (reset),
    .advance(1'b1),
    .count  (w_h_count),
    .phase  (w_h_phase),
    .wrap   (w_h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v_timer (
    .clock  (clock),
    .reset  (reset),
    .advance(w_h_wrap),
    .count  (w_v_count),
    .phase  (w_v_phase),
    .wrap   (w_v_wrap)
  );

  logic             r_hsync;
  logic             r_vsync;
  logic             r_display_enable;
  logic [CNT_W-1:0] r_pixel_x;
  logic [CNT_W-1:0] r_pixel_y;
  logic             r_line_end;
  logic             r_frame_start;
  logic             r_at_origin;

  // r_at_origin marks that the counters currently sit at (0,0); it is set by
  // the frame wrap rather than by a wide compare on both counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hsync          <= ~SYNC_ON;
      r_vsync          <= ~SYNC_ON;
      r_display_enable <= 1'b0;
      r_pixel_x        <= '0;
      r_pixel_y        <= '0;
      r_line_end       <= 1'b0;
      r_frame_start    <= 1'b0;
      r_at_origin      <= 1'b1;
    end else begin
      r_hsync          <= (w_h_phase == SYNC) ? SYNC_ON : ~SYNC_ON;
      r_vsync          <= (w_v_phase == SYNC) ? SYNC_ON : ~SYNC_ON;
      r_display_enable <= (w_h_phase == ACTIVE) && (w_v_phase == ACTIVE);
      r_pixel_x        <= w_h_count;
      r_pixel_y        <= w_v_count;
      r_line_end       <= w_h_wrap;
      r_frame_start    <= r_at_origin;
      r_at_origin      <= w_v_wrap;
    end
  end

  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign display_enable = r_display_enable;
  assign pixel_x        = r_pixel_x;
  assign pixel_y        = r_pixel_y;
  assign line_end       = r_line_end;
  assign frame_start    = r_frame_start;

endmodule
